// File: rtl/fetch_pkg.sv
// Shared fetch definitions: default reset PC, queue depth, and the queue entry
// payload. The fetch unit, the next-PC logic and decode all import this package.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned FETCH_DEPTH      = 2;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of fetched instructions.
// Ports: push/push_entry write the tail; pop retires the head; flush empties the
// queue and wins over push; count is the occupancy; head_valid/head_entry expose
// the registered head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic               head_valid,
  output fetch_entry_t       head_entry
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Ignore pops on empty and pushes that would overrun a full queue.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);

  assign head_valid = (count != '0);
  assign head_entry = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: holds the PC, issues sequential word fetches under
// a credit limit, tracks kept (live) and discarded (squash) in-flight requests,
// and buffers responses in fetch_queue for decode.
// Ports: clk/rst; redirect_valid/redirect_pc restart fetch at a new target;
// imem_req/imem_addr/imem_gnt request port; imem_rvalid/imem_rdata in-order
// responses; if_valid/if_instr/if_pc/if_ready decode handshake.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 2;

  logic [31:0]      pc;
  logic [CNT_W-1:0] live;
  logic [CNT_W-1:0] squash;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] occ;
  logic             pop;
  logic             grant;
  logic             squash_dec;
  logic             live_dec;
  logic             push;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  assign pop = if_valid & if_ready;

  // Credit counts the same-cycle pop so a streaming queue keeps one fetch per cycle.
  assign occ      = OCC_W'(live) + OCC_W'(squash) + OCC_W'(count) - OCC_W'(pop);
  assign imem_req = ~rst & ~redirect_valid & (occ < OCC_W'(DEPTH));
  assign grant    = imem_req & imem_gnt;
  assign imem_addr = pc;

  // Responses retire squashed requests first; only live ones are kept.
  assign squash_dec = imem_rvalid & (squash != '0);
  assign live_dec   = imem_rvalid & (squash == '0) & (live != '0);
  assign push       = live_dec & ~redirect_valid;

  // The oldest live request was issued live words behind the current PC.
  assign push_entry.pc    = pc - (32'(live) << 2);
  assign push_entry.instr = imem_rdata;

  // PC and in-flight request accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      live   <= '0;
      squash <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc & 32'hFFFF_FFFC;
      live   <= '0;
      squash <= squash - CNT_W'(squash_dec) + live - CNT_W'(live_dec);
    end else begin
      if (grant) begin
        pc <= pc + 32'd4;
      end
      live   <= live + CNT_W'(grant) - CNT_W'(live_dec);
      squash <= squash - CNT_W'(squash_dec);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head_valid (if_valid),
    .head_entry (head_entry)
  );

  assign if_instr = head_entry.instr;
  assign if_pc    = head_entry.pc;

endmodule
